// File: rtl/memcon_pkg.sv
// Shared encodings and defaults for the memcon MCB port arbiter.
package memcon_pkg;

  localparam logic [1:0] ARB_OWN   = 2'b00;
  localparam logic [1:0] ARB_DRAIN = 2'b01;
  localparam logic [1:0] ARB_IDLE  = 2'b10;
  localparam logic [1:0] ARB_RECOV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_RECOV
  } arb_fsm_e;

  localparam int DEF_TIMEOUT   = 4096;
  localparam int DEF_GUARD_CYC = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin picker: first set bit of vec at or after start, wrapping modulo N.
module arb_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the far end back toward start so the nearest hit is written last.
  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (|(vec & (N'(1) << j))) begin
        idx   = W'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memcon_arb.sv
// Time-shares one MCB user port among NREQ memcon requesters with a
// done/timeout release, guarded drain and hipri-first round-robin selection.
module memcon_arb
  import memcon_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int IDW       = 2,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic            memclk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] hipri,
  input  logic [NREQ-1:0] donep,
  input  logic            cmd_empty,
  output logic [NREQ-1:0] en,
  output logic [1:0]      arb_state,
  output logic [IDW-1:0]  owner,
  output logic            owner_vld,
  output logic            err,
  output logic [7:0]      timeout_cnt
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam int GW  = $clog2(GUARD_CYC + 1);

  arb_fsm_e        state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_nxt, rr_adv;
  logic [WDW-1:0]  wd, wd_nxt;
  logic [GW-1:0]   guard, guard_nxt;
  logic [NREQ-1:0] en_nxt, eligible;
  logic [1:0]      arb_nxt;
  logic [IDW-1:0]  owner_nxt, hi_idx, all_idx, pick_idx;
  logic            vld_nxt, err_nxt, hi_found, all_found, owner_done;
  logic [7:0]      tcnt_nxt;

  // A requester still asserting done from its last burst set is not eligible.
  assign eligible   = req & ~donep;
  assign owner_done = |(donep & en);
  assign rr_adv     = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
  assign pick_idx   = hi_found ? hi_idx : all_idx;

  arb_rr_pick #(.N(NREQ), .W(IDW)) u_pick_hi (
    .vec   (eligible & hipri),
    .start (rr_ptr),
    .idx   (hi_idx),
    .found (hi_found)
  );

  arb_rr_pick #(.N(NREQ), .W(IDW)) u_pick_all (
    .vec   (eligible),
    .start (rr_ptr),
    .idx   (all_idx),
    .found (all_found)
  );

  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    arb_nxt   = arb_state;
    owner_nxt = owner;
    vld_nxt   = owner_vld;
    err_nxt   = err;
    tcnt_nxt  = timeout_cnt;
    rr_nxt    = rr_ptr;
    wd_nxt    = wd;
    guard_nxt = guard;
    case (state)
      ST_IDLE: begin
        arb_nxt = ARB_IDLE;
        if (all_found) begin
          en_nxt    = NREQ'(1) << pick_idx;
          owner_nxt = pick_idx;
          vld_nxt   = 1'b1;
          arb_nxt   = ARB_OWN;
          wd_nxt    = '0;
          state_nxt = ST_GRANT;
        end
      end
      // Done beats a coincident watchdog expiry, so no error is logged then.
      ST_GRANT: begin
        if (owner_done) begin
          en_nxt    = '0;
          vld_nxt   = 1'b0;
          arb_nxt   = ARB_DRAIN;
          rr_nxt    = rr_adv;
          guard_nxt = '0;
          state_nxt = ST_DRAIN;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          en_nxt    = '0;
          vld_nxt   = 1'b0;
          err_nxt   = 1'b1;
          arb_nxt   = ARB_RECOV;
          rr_nxt    = rr_adv;
          guard_nxt = '0;
          state_nxt = ST_RECOV;
          if (timeout_cnt != 8'hFF) tcnt_nxt = timeout_cnt + 8'd1;
        end else begin
          wd_nxt = wd + WDW'(1);
        end
      end
      ST_DRAIN, ST_RECOV: begin
        if (guard >= GW'(GUARD_CYC - 1)) begin
          if (cmd_empty) begin
            arb_nxt   = ARB_IDLE;
            state_nxt = ST_IDLE;
          end
        end else begin
          guard_nxt = guard + GW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      en          <= '0;
      arb_state   <= ARB_IDLE;
      owner       <= '0;
      owner_vld   <= 1'b0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      rr_ptr      <= '0;
      wd          <= '0;
      guard       <= '0;
    end else begin
      state       <= state_nxt;
      en          <= en_nxt;
      arb_state   <= arb_nxt;
      owner       <= owner_nxt;
      owner_vld   <= vld_nxt;
      err         <= err_nxt;
      timeout_cnt <= tcnt_nxt;
      rr_ptr      <= rr_nxt;
      wd          <= wd_nxt;
      guard       <= guard_nxt;
    end
  end

endmodule

// File: tb/tb_memcon_arb.sv
// Directed bench for memcon_arb: grant order is scoreboarded, all other points checked inline.
module tb_memcon_arb;
  import memcon_pkg::*;

  logic       memclk = 1'b0;
  logic       rst;
  logic [2:0] req, hipri, donep;
  logic       cmd_empty;
  logic [2:0] en;
  logic [1:0] arb_state, owner;
  logic       owner_vld, err;
  logic [7:0] timeout_cnt;

  logic [2:0] req_t, hipri_t, donep_t;
  logic       cmd_empty_t;
  logic [2:0] en_t;
  logic [1:0] arb_state_t, owner_t;
  logic       owner_vld_t, err_t;
  logic [7:0] timeout_cnt_t;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic prev_vld = 1'b0;

  always #5 memclk = ~memclk;

  memcon_arb #(.NREQ(3), .IDW(2)) dut (
    .memclk(memclk), .rst(rst), .req(req), .hipri(hipri), .donep(donep),
    .cmd_empty(cmd_empty), .en(en), .arb_state(arb_state), .owner(owner),
    .owner_vld(owner_vld), .err(err), .timeout_cnt(timeout_cnt)
  );

  memcon_arb #(.NREQ(3), .IDW(2), .TIMEOUT(16), .GUARD_CYC(4)) dut_to (
    .memclk(memclk), .rst(rst), .req(req_t), .hipri(hipri_t), .donep(donep_t),
    .cmd_empty(cmd_empty_t), .en(en_t), .arb_state(arb_state_t), .owner(owner_t),
    .owner_vld(owner_vld_t), .err(err_t), .timeout_cnt(timeout_cnt_t)
  );

  task automatic step(input int n);
    repeat (n) @(posedge memclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each new grant on dut is matched against the next owner queued by the stimulus.
  always @(negedge memclk) begin
    int e;
    logic [2:0] one;
    if (owner_vld && !prev_vld) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_grant: observed owner %0d expected none", owner);
      end
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        one = 3'b001;
        checks++;
        assert ({owner, en} === {2'(e), one << e}) else begin
          errors++;
          $error("[TB] FAIL grant_order: observed owner %0d en %b expected owner %0d en %b",
                 owner, en, e, one << e);
        end
      end
    end
    prev_vld = owner_vld;
  end

  initial begin
    int order[4];
    logic [2:0] one;
    one = 3'b001;
    order = '{1, 2, 1, 2};
    rst = 1'b1; req = '0; hipri = '0; donep = '0; cmd_empty = 1'b1;
    req_t = '0; hipri_t = '0; donep_t = '0; cmd_empty_t = 1'b1;

    step(2);
    check_output("rst_en", en, 0);
    check_output("rst_state", arb_state, ARB_IDLE);
    check_output("rst_owner", {owner_vld, owner}, 0);
    check_output("rst_err_cnt", {err, timeout_cnt}, 0);
    rst = 1'b0;
    step(1);
    check_output("idle_noreq", arb_state, ARB_IDLE);

    $display("[TB] single requester");
    req = 3'b001; exp_q.push_back(0);
    step(1);
    check_output("single_en", en, 3'b001);
    check_output("single_own", {owner_vld, arb_state}, {1'b1, ARB_OWN});
    step(49);
    check_output("single_hold", en, 3'b001);
    donep = 3'b001;
    step(1);
    check_output("single_rel_en", {owner_vld, en}, 0);
    check_output("single_rel_st", arb_state, ARB_DRAIN);
    check_output("single_last_owner", owner, 0);
    step(3);
    check_output("single_guard", arb_state, ARB_DRAIN);
    donep = 3'b000; exp_q.push_back(0);
    step(1);
    check_output("single_idle", {arb_state, en}, {ARB_IDLE, 3'b000});
    step(1);
    check_output("single_regrant", en, 3'b001);
    donep = 3'b001;
    step(1);
    check_output("single_rel2", arb_state, ARB_DRAIN);
    step(7);
    check_output("single_done_block", {arb_state, en}, {ARB_IDLE, 3'b000});
    req = 3'b000; donep = 3'b000;
    step(2);
    check_output("single_quiet", {arb_state, en}, {ARB_IDLE, 3'b000});

    $display("[TB] round robin");
    req = 3'b110; exp_q.push_back(order[0]);
    step(1);
    for (int k = 0; k < 4; k++) begin
      step(9);
      donep = one << order[k];
      if (k == 3) req = 3'b000;
      step(1);
      check_output("rr_drain", arb_state, ARB_DRAIN);
      donep = 3'b000;
      if (k < 3) exp_q.push_back(order[k + 1]);
      step(5);
    end
    check_output("rr_end", {arb_state, en}, {ARB_IDLE, 3'b000});

    $display("[TB] priority");
    hipri = 3'b100; req = 3'b001; exp_q.push_back(0);
    step(1);
    req = 3'b011;
    step(3);
    req = 3'b111;
    step(5);
    check_output("pri_no_preempt", {owner, en}, {2'd0, 3'b001});
    donep = 3'b001; req = 3'b110; exp_q.push_back(2); exp_q.push_back(1);
    step(1);
    check_output("pri_drain", arb_state, ARB_DRAIN);
    donep = 3'b000;
    step(5);
    check_output("pri_hi_first", en, 3'b100);
    step(3);
    donep = 3'b100; req = 3'b010;
    step(1);
    donep = 3'b000;
    step(5);
    check_output("pri_then_1", en, 3'b010);
    step(3);
    donep = 3'b010; req = 3'b000;
    step(1);
    donep = 3'b000; hipri = 3'b000;
    step(5);
    check_output("pri_end", arb_state, ARB_IDLE);

    $display("[TB] drain stall and foreign done");
    req = 3'b001; exp_q.push_back(0);
    step(3);
    donep = 3'b100;
    step(1);
    check_output("foreign_done", {arb_state, en}, {ARB_OWN, 3'b001});
    donep = 3'b000;
    step(3);
    cmd_empty = 1'b0; donep = 3'b001; req = 3'b000;
    step(1);
    check_output("stall_enter", arb_state, ARB_DRAIN);
    donep = 3'b000;
    step(19);
    check_output("stall_hold", arb_state, ARB_DRAIN);
    cmd_empty = 1'b1;
    step(1);
    check_output("stall_exit", arb_state, ARB_IDLE);

    $display("[TB] timeout");
    req_t = 3'b010;
    step(1);
    check_output("to_grant", en_t, 3'b010);
    step(15);
    check_output("to_hold", en_t, 3'b010);
    step(1);
    check_output("to_release", {en_t, arb_state_t}, {3'b000, ARB_RECOV});
    check_output("to_err", {err_t, timeout_cnt_t}, {1'b1, 8'd1});
    step(21 * 253);
    check_output("to_cnt_254", {arb_state_t, timeout_cnt_t}, {ARB_RECOV, 8'd254});
    step(21 * 46);
    check_output("to_cnt_sat", {arb_state_t, err_t, timeout_cnt_t}, {ARB_RECOV, 1'b1, 8'd255});
    req_t = 3'b000;
    step(30);

    $display("[TB] reset mid-grant");
    req = 3'b001; exp_q.push_back(0);
    step(4);
    #3 rst = 1'b1;
    #1;
    check_output("rst_async_en", {owner_vld, en}, 0);
    check_output("rst_async_st", {arb_state, err}, {ARB_IDLE, 1'b0});
    check_output("rst_async_to", {err_t, timeout_cnt_t}, 0);
    @(posedge memclk);
    #1 rst = 1'b0; req = 3'b101; exp_q.push_back(0);
    step(1);
    check_output("rst_rr_zero", en, 3'b001);
    step(3);
    donep = 3'b001; req = 3'b000;
    step(1);
    donep = 3'b000;
    step(6);
    check_output("final_idle", {arb_state, err}, {ARB_IDLE, 1'b0});
    check_output("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
